// File: rtl/reg_mode_ctrl_pkg.sv
// Shared encodings for the register-file bank mode controller.
package reg_mode_pkg;

    typedef enum logic [1:0] {
        OP_NOP        = 2'b00,
        OP_TOGGLE     = 2'b01,
        OP_SET_KERNEL = 2'b10,
        OP_SET_PROG   = 2'b11
    } cmd_op_e;

    localparam logic MODE_PROG   = 1'b0;
    localparam logic MODE_KERNEL = 1'b1;

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/reg_mode_ctrl_if.sv
// Control-unit side command/trap bus and mode status of the bank-select controller.
interface reg_mode_if #(
    parameter int NUM_CH      = 2,
    parameter int STACK_DEPTH = 4
) ();
    localparam int LW = $clog2(STACK_DEPTH) + 1;

    logic              cmd_valid;
    logic [1:0]        cmd_op;
    logic [NUM_CH-1:0] cmd_mask;
    logic              trap_req;
    logic              ret_req;
    logic              err_clr;
    logic [NUM_CH-1:0] mode;
    logic              mode_changed;
    logic [LW-1:0]     stack_level;
    logic              overflow;
    logic              underflow;

    modport master (
        output cmd_valid, cmd_op, cmd_mask, trap_req, ret_req, err_clr,
        input  mode, mode_changed, stack_level, overflow, underflow
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_mask, trap_req, ret_req, err_clr,
        output mode, mode_changed, stack_level, overflow, underflow
    );
endinterface

// File: rtl/reg_mode_ctrl_shadow_stack.sv
// LIFO of saved mode vectors; the parent decides when push/pop are legal.
module mode_shadow_stack #(
    parameter int NUM_CH      = 2,
    parameter int STACK_DEPTH = 4
) (
    input  logic                           i_clock,
    input  logic                           i_reset_n,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  logic [NUM_CH-1:0]              i_data,
    output logic [NUM_CH-1:0]              o_top,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [$clog2(STACK_DEPTH):0]   o_level
);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam int LW = AW + 1;

    logic [NUM_CH-1:0] r_mem [STACK_DEPTH];
    logic [LW-1:0]     r_level;
    logic [LW-1:0]     w_level_m1;
    logic [AW-1:0]     w_wr_idx;
    logic [AW-1:0]     w_rd_idx;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full     = (r_level == LW'(STACK_DEPTH));
    assign o_empty    = (r_level == '0);
    assign o_level    = r_level;
    assign w_level_m1 = r_level - LW'(1);
    assign w_wr_idx   = r_level[AW-1:0];
    assign w_rd_idx   = w_level_m1[AW-1:0];
    assign o_top      = r_mem[w_rd_idx];
    // Guards keep the level saturating at both ends even if a caller misbehaves.
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty && !i_push;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n)     r_level <= '0;
        else if (w_do_push) r_level <= r_level + LW'(1);
        else if (w_do_pop)  r_level <= w_level_m1;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset_n && w_do_push) r_mem[w_wr_idx] <= i_data;
    end

endmodule

// File: rtl/reg_mode_ctrl.sv
// Per-operand-channel program/kernel bank mode register with trap save/restore.
module reg_mode_ctrl
    import reg_mode_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int STACK_DEPTH = 4
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    reg_mode_if.slave  bus
);
    localparam int LW = $clog2(STACK_DEPTH) + 1;

    logic [NUM_CH-1:0] r_mode;
    logic [NUM_CH-1:0] r_mode_d;
    logic              r_mode_changed;
    logic              r_overflow;
    logic              r_underflow;

    logic [NUM_CH-1:0] w_mode_nxt;
    logic [NUM_CH-1:0] w_top;
    logic [LW-1:0]     w_level;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_ovf_set;
    logic              w_unf_set;

    mode_shadow_stack #(
        .NUM_CH      (NUM_CH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_data    (r_mode),
        .o_top     (w_top),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (w_level)
    );

    // Strict priority trap > ret > cmd; losers in a cycle are dropped.
    always_comb begin
        w_mode_nxt = r_mode;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_ovf_set  = 1'b0;
        w_unf_set  = 1'b0;
        if (bus.trap_req) begin
            w_mode_nxt = {NUM_CH{MODE_KERNEL}};
            w_push     = !w_full;
            w_ovf_set  = w_full;
        end else if (bus.ret_req) begin
            if (!w_empty) begin
                w_mode_nxt = w_top;
                w_pop      = 1'b1;
            end else begin
                w_unf_set  = 1'b1;
            end
        end else if (bus.cmd_valid) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.cmd_mask[i]) begin
                    case (cmd_op_e'(bus.cmd_op))
                        OP_TOGGLE:     w_mode_nxt[i] = ~r_mode[i];
                        OP_SET_KERNEL: w_mode_nxt[i] = MODE_KERNEL;
                        OP_SET_PROG:   w_mode_nxt[i] = MODE_PROG;
                        default:       w_mode_nxt[i] = r_mode[i];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_mode         <= {NUM_CH{MODE_PROG}};
            r_mode_d       <= {NUM_CH{MODE_PROG}};
            r_mode_changed <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_mode         <= w_mode_nxt;
            r_mode_d       <= r_mode;
            r_mode_changed <= (r_mode != r_mode_d);
            // An error event in the same cycle as err_clr keeps the flag set.
            r_overflow     <= w_ovf_set | (r_overflow  & ~bus.err_clr);
            r_underflow    <= w_unf_set | (r_underflow & ~bus.err_clr);
        end
    end

    assign bus.mode         = r_mode;
    assign bus.mode_changed = r_mode_changed;
    assign bus.stack_level  = w_level;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_reg_mode_ctrl.sv
// Directed bench for reg_mode_ctrl with NUM_CH=2, STACK_DEPTH=4.
module tb_reg_mode_ctrl;
    import reg_mode_pkg::*;

    logic clk;
    logic rst_n;
    int   n_asrt;
    int   n_fail;

    reg_mode_if #(.NUM_CH(2), .STACK_DEPTH(4)) bus ();

    reg_mode_ctrl #(.NUM_CH(2), .STACK_DEPTH(4)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_mask  = 2'b00;
        bus.trap_req  = 1'b0;
        bus.ret_req   = 1'b0;
        bus.err_clr   = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] m, input logic chg,
                           input logic [2:0] lvl, input logic ov, input logic un);
        chk({tag, "/mode"},  32'(bus.mode),         32'(m));
        chk({tag, "/chg"},   32'(bus.mode_changed), 32'(chg));
        chk({tag, "/level"}, 32'(bus.stack_level),  32'(lvl));
        chk({tag, "/ovf"},   32'(bus.overflow),     32'(ov));
        chk({tag, "/unf"},   32'(bus.underflow),    32'(un));
    endtask

    task automatic cmd(input logic [1:0] op, input logic [1:0] mask);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_mask  = mask;
        cyc();
        idle();
    endtask

    task automatic trap();
        bus.trap_req = 1'b1;
        cyc();
        idle();
    endtask

    task automatic ret();
        bus.ret_req = 1'b1;
        cyc();
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_asrt = 0;
        n_fail = 0;
        idle();
        rst_n = 1'b0;
        cyc();
        cyc();
        chk_all("reset", 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc();
        chk_all("idle_after_reset", 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);

        cmd(OP_TOGGLE, 2'b01);
        chk_all("tog01", 2'b01, 1'b0, 3'd0, 1'b0, 1'b0);
        cyc();
        chk_all("tog01_pulse", 2'b01, 1'b1, 3'd0, 1'b0, 1'b0);
        cyc();
        chk("tog01_pulse_end", 32'(bus.mode_changed), 32'd0);
        cmd(OP_TOGGLE, 2'b11);
        chk("tog11", 32'(bus.mode), 32'h2);
        cyc();
        chk("tog11_pulse", 32'(bus.mode_changed), 32'd1);

        cmd(OP_SET_PROG, 2'b11);
        chk("clear_all", 32'(bus.mode), 32'h0);
        cyc();
        cmd(OP_SET_KERNEL, 2'b10);
        chk("setk10", 32'(bus.mode), 32'h2);
        cyc();
        cmd(OP_SET_PROG, 2'b11);
        chk("setp11", 32'(bus.mode), 32'h0);
        cyc();
        cmd(OP_SET_KERNEL, 2'b10);
        cyc();
        cmd(OP_SET_KERNEL, 2'b10);
        chk("setk_again_mode", 32'(bus.mode), 32'h2);
        cyc();
        chk("setk_again_nochg", 32'(bus.mode_changed), 32'd0);
        cmd(OP_NOP, 2'b11);
        chk("nop", 32'(bus.mode), 32'h2);
        cmd(OP_TOGGLE, 2'b00);
        chk("mask0", 32'(bus.mode), 32'h2);

        cmd(OP_SET_PROG, 2'b11);
        cmd(OP_TOGGLE, 2'b01);
        cyc();
        trap();
        chk_all("trap1", 2'b11, 1'b0, 3'd1, 1'b0, 1'b0);
        cmd(OP_SET_PROG, 2'b11);
        chk("in_trap_clear", 32'(bus.mode), 32'h0);
        ret();
        chk_all("ret1", 2'b01, 1'b1, 3'd0, 1'b0, 1'b0);

        trap();
        cmd(OP_SET_PROG, 2'b11);
        trap();
        cmd(OP_SET_PROG, 2'b01);
        trap();
        chk("lvl3", 32'(bus.stack_level), 32'd3);
        trap();
        chk_all("trap4", 2'b11, 1'b1, 3'd4, 1'b0, 1'b0);
        trap();
        chk_all("trap5_ovf", 2'b11, 1'b0, 3'd4, 1'b1, 1'b0);
        ret();
        chk_all("pop1", 2'b11, 1'b0, 3'd3, 1'b1, 1'b0);
        ret();
        chk_all("pop2", 2'b10, 1'b0, 3'd2, 1'b1, 1'b0);
        ret();
        chk_all("pop3", 2'b00, 1'b1, 3'd1, 1'b1, 1'b0);
        ret();
        chk_all("pop4", 2'b01, 1'b1, 3'd0, 1'b1, 1'b0);
        ret();
        chk_all("pop5_unf", 2'b01, 1'b1, 3'd0, 1'b1, 1'b1);
        bus.err_clr = 1'b1;
        cyc();
        idle();
        chk_all("err_clr", 2'b01, 1'b0, 3'd0, 1'b0, 1'b0);

        bus.trap_req  = 1'b1;
        bus.ret_req   = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_TOGGLE;
        bus.cmd_mask  = 2'b11;
        cyc();
        idle();
        chk_all("prio_trap", 2'b11, 1'b0, 3'd1, 1'b0, 1'b0);
        bus.ret_req   = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_SET_PROG;
        bus.cmd_mask  = 2'b11;
        cyc();
        idle();
        chk_all("prio_ret", 2'b01, 1'b1, 3'd0, 1'b0, 1'b0);
        bus.ret_req = 1'b1;
        bus.err_clr = 1'b1;
        cyc();
        idle();
        chk("set_wins_unf", 32'(bus.underflow), 32'd1);
        bus.err_clr = 1'b1;
        cyc();
        idle();
        chk("clr_unf", 32'(bus.underflow), 32'd0);

        trap();
        trap();
        trap();
        chk("pre_reset_lvl", 32'(bus.stack_level), 32'd3);
        rst_n = 1'b0;
        bus.trap_req = 1'b1;
        cyc();
        idle();
        rst_n = 1'b1;
        chk_all("mid_reset", 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);
        ret();
        chk_all("ret_after_reset", 2'b00, 1'b0, 3'd0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
